axi4_memory: RTL and testbench
==============================

AXI4_MEMORY -- requirements
Module: axi4_memory

Interface
REQ-001 SHALL have parameter AXI_TEST, default 0: when 1, pseudo-random stalls are inserted on ready/response signals.
REQ-002 SHALL have parameter VERBOSE, default 0: when 1, each completed transaction is printed in simulation.
REQ-003 SHALL have parameter MEM_WORDS, default 32768: number of 32-bit words in the array (128 KiB).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 mem_axi_awvalid/awready  in/out  1/1  write-address handshake; mem_axi_awaddr in 32 byte address; mem_axi_awprot in 3, ignored.
REQ-007 mem_axi_wvalid/wready  in/out  1/1  write-data handshake; mem_axi_wdata in 32; mem_axi_wstrb in 4 byte enables (bit i = byte i).
REQ-008 mem_axi_bvalid/bready  out/in  1/1  write response.
REQ-009 mem_axi_arvalid/arready  in/out  1/1  read-address handshake; mem_axi_araddr in 32; mem_axi_arprot in 3, ignored.
REQ-010 mem_axi_rvalid/rready  out/in  1/1  read response; mem_axi_rdata out 32.
REQ-011 should_exit  output  1  sticky end-of-simulation request; exit_code  output  16  code accompanying it.
REQ-012 SHALL expose the storage as an unpacked array named memory, [0:MEM_WORDS-1] of 32 bits, loadable by hierarchical $readmemh; word i holds byte address 4*i..4*i+3, little-endian.

Function
REQ-013 Write channel: aw_hold and w_hold registers; awready = !aw_hold && !bvalid && gate_aw; wready = !w_hold && !bvalid && gate_w; a handshake at edge N sets the hold and captures addr (or data+strb).
REQ-014 At an edge where aw_hold && w_hold && !bvalid && gate_wc: perform the write, clear both holds, set bvalid; bvalid then holds until an edge with bready=1.
REQ-015 Write latency (AXI_TEST=0): last of AW/W handshakes at edge N -> bvalid visible after edge N+1; AW and W accepted in any order or same cycle.
REQ-016 Normal write: address < 4*MEM_WORDS -> update only bytes whose wstrb bit is 1 of memory[addr[31:2]]; addr[1:0] ignored.
REQ-017 Write to 0x1000_0000: print character wdata[7:0] via $write; memory unchanged.
REQ-018 Write to 0x2000_0000: set should_exit=1, exit_code=wdata[15:0].
REQ-019 Any other write address: ignored; should_exit=1, exit_code=16'hFFFF; bresp still returned (bvalid).
REQ-020 Read channel: arready = !ar_hold && !rvalid && gate_ar; handshake at edge N latches address; at edge N+1 (if gate_rd) rdata loaded, rvalid=1, ar_hold cleared; rvalid/rdata stable until edge with rready=1.
REQ-021 Read in range -> memory[addr[31:2]]; out of range -> rdata=0, should_exit=1, exit_code=16'hFFFF.
REQ-022 At most one outstanding read and one outstanding write; read and write channels fully independent; same-cycle read and write to same word: read returns pre-write data if its load edge precedes or equals the commit edge.
REQ-023 once should_exit=1 it stays 1 until reset; later exit writes update exit_code only if it is 0 (first code wins unless 0).
REQ-024 AXI_TEST=0: all gate_* = 1. AXI_TEST=1: 32-bit xorshift (x^=x<<13; x^=x>>17; x^=x<<5) advancing every cycle, seed 32'd123456789; gate_aw=bit0, gate_w=bit1, gate_ar=bit2, gate_wc=bit3, gate_rd=bit4.
REQ-025 VERBOSE=1: $display "WR addr data strb" on commit and "RD addr data" on read load.

Reset
REQ-026 resetn=0 at an edge: aw_hold, w_hold, ar_hold, bvalid, rvalid, should_exit=0; exit_code=0; rdata=0; LFSR=seed; memory contents preserved.
REQ-027 Reset mid-transaction discards held address/data without writing memory.

Verification
REQ-028 Reset 2 cycles (AXI_TEST=0) -> bvalid=rvalid=should_exit=0, awready=wready=arready=1.
REQ-029 AW 0x100 + W 0xA5A5A5A5 strb F same cycle -> bvalid one cycle later; read 0x100 -> rdata 0xA5A5A5A5 one cycle after AR handshake.
REQ-030 Write 0x11223344 to 0x200, then data 0x0000BB00 strb 0010 -> read 0x200 returns 0x1122BB44.
REQ-031 AW 3 cycles before W, bready low 2 cycles -> bvalid held 2 cycles, awready/wready low until B accepted.
REQ-032 Write 0x2000_0000 data 7 -> should_exit=1, exit_code=7 after commit; read 0x0010_0000 -> rdata 0, exit_code unchanged 7.
REQ-033 AXI_TEST=1, 1000 random reads/writes vs reference model -> all data match, no protocol violation (valid stable until ready).

Source files
------------

// File: rtl/axi4_memory.sv
// Simulation AXI4-lite style memory: one outstanding read and one outstanding write,
// console and exit mailboxes, optional pseudo-random back-pressure for protocol testing.
module axi4_memory #(
  parameter int unsigned AXI_TEST  = 0,
  parameter int unsigned VERBOSE   = 0,
  parameter int unsigned MEM_WORDS = 32768
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,

  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,

  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,

  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,

  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,

  output logic        should_exit,
  output logic [15:0] exit_code
);

  localparam int unsigned IDX_W        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_BYTES    = 32'(4 * MEM_WORDS);
  localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] EXIT_ADDR    = 32'h2000_0000;
  localparam logic [31:0] LFSR_SEED    = 32'd123456789;
  localparam logic [15:0] BAD_CODE     = 16'hFFFF;

  logic [31:0] memory [0:MEM_WORDS-1];

  logic              aw_hold_q, aw_hold_d;
  logic              w_hold_q, w_hold_d;
  logic              ar_hold_q, ar_hold_d;
  logic              bvalid_q, bvalid_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       aw_addr_q, aw_addr_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic [31:0]       ar_addr_q, ar_addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              should_exit_q, should_exit_d;
  logic [15:0]       exit_code_q, exit_code_d;
  logic [31:0]       lfsr_q, lfsr_d;

  logic [31:0]       lfsr_s1, lfsr_s2;
  logic              gate_aw, gate_w, gate_ar, gate_wc, gate_rd;
  logic              aw_hs, w_hs, ar_hs;
  logic              wr_commit, rd_load;
  logic              wr_in_range, wr_console, wr_exit, wr_bad;
  logic              rd_in_range;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [31:0]       wr_word;

  logic              unused_prot;
  assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot};

  // xorshift32 stall generator; only its low bits matter, and only when AXI_TEST is set
  always_comb begin
    lfsr_s1 = lfsr_q ^ (lfsr_q << 13);
    lfsr_s2 = lfsr_s1 ^ (lfsr_s1 >> 17);
    lfsr_d  = lfsr_s2 ^ (lfsr_s2 << 5);
  end

  always_comb begin
    gate_aw = (AXI_TEST == 0) || lfsr_q[0];
    gate_w  = (AXI_TEST == 0) || lfsr_q[1];
    gate_ar = (AXI_TEST == 0) || lfsr_q[2];
    gate_wc = (AXI_TEST == 0) || lfsr_q[3];
    gate_rd = (AXI_TEST == 0) || lfsr_q[4];
  end

  assign mem_axi_awready = !aw_hold_q && !bvalid_q && gate_aw;
  assign mem_axi_wready  = !w_hold_q && !bvalid_q && gate_w;
  assign mem_axi_arready = !ar_hold_q && !rvalid_q && gate_ar;
  assign mem_axi_bvalid  = bvalid_q;
  assign mem_axi_rvalid  = rvalid_q;
  assign mem_axi_rdata   = rdata_q;
  assign should_exit     = should_exit_q;
  assign exit_code       = exit_code_q;

  always_comb begin
    aw_hs     = mem_axi_awvalid && mem_axi_awready;
    w_hs      = mem_axi_wvalid && mem_axi_wready;
    ar_hs     = mem_axi_arvalid && mem_axi_arready;
    wr_commit = aw_hold_q && w_hold_q && !bvalid_q && gate_wc;
    rd_load   = ar_hold_q && gate_rd;
  end

  // Address decode of the held write and read addresses
  always_comb begin
    wr_in_range = aw_addr_q < MEM_BYTES;
    wr_console  = !wr_in_range && (aw_addr_q == CONSOLE_ADDR);
    wr_exit     = !wr_in_range && (aw_addr_q == EXIT_ADDR);
    wr_bad      = !wr_in_range && !wr_console && !wr_exit;
    rd_in_range = ar_addr_q < MEM_BYTES;
    wr_idx      = aw_addr_q[IDX_W+1:2];
    rd_idx      = ar_addr_q[IDX_W+1:2];
  end

  // Byte-lane merge of the held write data into the addressed word
  always_comb begin
    wr_word = memory[wr_idx];
    for (int i = 0; i < 4; i++) begin
      if (w_strb_q[i]) begin
        wr_word[8*i +: 8] = w_data_q[8*i +: 8];
      end
    end
  end

  // Write channel: capture AW and W independently, commit once both are held
  always_comb begin
    aw_hold_d = aw_hold_q;
    w_hold_d  = w_hold_q;
    bvalid_d  = bvalid_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    if (aw_hs) begin
      aw_hold_d = 1'b1;
      aw_addr_d = mem_axi_awaddr;
    end
    if (w_hs) begin
      w_hold_d = 1'b1;
      w_data_d = mem_axi_wdata;
      w_strb_d = mem_axi_wstrb;
    end
    if (wr_commit) begin
      aw_hold_d = 1'b0;
      w_hold_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else if (bvalid_q && mem_axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Read channel: latch address, load data on a later edge, hold until accepted
  always_comb begin
    ar_hold_d = ar_hold_q;
    rvalid_d  = rvalid_q;
    ar_addr_d = ar_addr_q;
    rdata_d   = rdata_q;
    if (ar_hs) begin
      ar_hold_d = 1'b1;
      ar_addr_d = mem_axi_araddr;
    end
    if (rd_load) begin
      ar_hold_d = 1'b0;
      rvalid_d  = 1'b1;
      rdata_d   = rd_in_range ? memory[rd_idx] : 32'h0;
    end else if (rvalid_q && mem_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Exit mailbox: sticky flag, first non-zero code wins; a write on the same edge beats a read
  always_comb begin
    should_exit_d = should_exit_q;
    exit_code_d   = exit_code_q;
    if (rd_load && !rd_in_range) begin
      should_exit_d = 1'b1;
      if (exit_code_q == 16'h0) exit_code_d = BAD_CODE;
    end
    if (wr_commit && (wr_exit || wr_bad)) begin
      should_exit_d = 1'b1;
      if (exit_code_q == 16'h0) exit_code_d = wr_exit ? w_data_q[15:0] : BAD_CODE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_hold_q     <= 1'b0;
      w_hold_q      <= 1'b0;
      ar_hold_q     <= 1'b0;
      bvalid_q      <= 1'b0;
      rvalid_q      <= 1'b0;
      aw_addr_q     <= 32'h0;
      w_data_q      <= 32'h0;
      w_strb_q      <= 4'h0;
      ar_addr_q     <= 32'h0;
      rdata_q       <= 32'h0;
      should_exit_q <= 1'b0;
      exit_code_q   <= 16'h0;
      lfsr_q        <= LFSR_SEED;
    end else begin
      aw_hold_q     <= aw_hold_d;
      w_hold_q      <= w_hold_d;
      ar_hold_q     <= ar_hold_d;
      bvalid_q      <= bvalid_d;
      rvalid_q      <= rvalid_d;
      aw_addr_q     <= aw_addr_d;
      w_data_q      <= w_data_d;
      w_strb_q      <= w_strb_d;
      ar_addr_q     <= ar_addr_d;
      rdata_q       <= rdata_d;
      should_exit_q <= should_exit_d;
      exit_code_q   <= exit_code_d;
      lfsr_q        <= lfsr_d;
    end
  end

  // Storage keeps its contents through reset; a commit coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (resetn && wr_commit && wr_in_range) begin
      memory[wr_idx] <= wr_word;
    end
  end

  // Simulation-only console output and transaction trace
  always @(posedge clk) begin
    if (resetn && wr_commit) begin
      if (wr_console) $write("%c", w_data_q[7:0]);
      if (VERBOSE != 0) $display("WR %08x %08x %1x", aw_addr_q, w_data_q, w_strb_q);
    end
    if (resetn && rd_load && (VERBOSE != 0)) begin
      $display("RD %08x %08x", ar_addr_q, rdata_d);
    end
  end

endmodule

// File: tb/tb_axi4_memory.sv
// Scoreboard bench: directed timing checks on an unstalled instance, then randomized
// traffic against a byte-level memory model on an instance with random back-pressure.
module tb_axi4_memory;

  localparam int unsigned MEM_WORDS = 32768;
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
  localparam int unsigned N_RAND    = 1000;
  localparam int          TMO       = 400;

  logic        clk = 1'b0;
  logic        resetn;
  logic        awvalid [2];
  logic        awready [2];
  logic [31:0] awaddr  [2];
  logic        wvalid  [2];
  logic        wready  [2];
  logic [31:0] wdata   [2];
  logic [3:0]  wstrb   [2];
  logic        bvalid  [2];
  logic        bready  [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] araddr  [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic [31:0] rdata   [2];
  logic        sx      [2];
  logic [15:0] ecode   [2];

  always #5 clk = ~clk;

  axi4_memory #(.AXI_TEST(0), .VERBOSE(0), .MEM_WORDS(MEM_WORDS)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(awvalid[0]), .mem_axi_awready(awready[0]), .mem_axi_awaddr(awaddr[0]), .mem_axi_awprot(3'b000),
    .mem_axi_wvalid(wvalid[0]), .mem_axi_wready(wready[0]), .mem_axi_wdata(wdata[0]), .mem_axi_wstrb(wstrb[0]),
    .mem_axi_bvalid(bvalid[0]), .mem_axi_bready(bready[0]),
    .mem_axi_arvalid(arvalid[0]), .mem_axi_arready(arready[0]), .mem_axi_araddr(araddr[0]), .mem_axi_arprot(3'b000),
    .mem_axi_rvalid(rvalid[0]), .mem_axi_rready(rready[0]), .mem_axi_rdata(rdata[0]),
    .should_exit(sx[0]), .exit_code(ecode[0])
  );

  axi4_memory #(.AXI_TEST(1), .VERBOSE(0), .MEM_WORDS(MEM_WORDS)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(awvalid[1]), .mem_axi_awready(awready[1]), .mem_axi_awaddr(awaddr[1]), .mem_axi_awprot(3'b000),
    .mem_axi_wvalid(wvalid[1]), .mem_axi_wready(wready[1]), .mem_axi_wdata(wdata[1]), .mem_axi_wstrb(wstrb[1]),
    .mem_axi_bvalid(bvalid[1]), .mem_axi_bready(bready[1]),
    .mem_axi_arvalid(arvalid[1]), .mem_axi_arready(arready[1]), .mem_axi_araddr(araddr[1]), .mem_axi_arprot(3'b000),
    .mem_axi_rvalid(rvalid[1]), .mem_axi_rready(rready[1]), .mem_axi_rdata(rdata[1]),
    .should_exit(sx[1]), .exit_code(ecode[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sparse word store over a known preload pattern
  logic [31:0] mem_m [longint];
  logic [31:0] rexp0 [$];
  logic [31:0] rexp1 [$];
  int          bexp  [2];

  function automatic logic [31:0] init_word(input int d, input int unsigned i);
    return (32'(i) * 32'h9E3779B9) ^ 32'(d + 1);
  endfunction

  function automatic longint mkey(input int d, input logic [31:0] a);
    return (longint'(d) << 32) | longint'(a[31:2]);
  endfunction

  function automatic logic [31:0] model_rd(input int d, input logic [31:0] a);
    if (a >= MEM_BYTES) return 32'h0;
    if (mem_m.exists(mkey(d, a))) return mem_m[mkey(d, a)];
    return init_word(d, 32'(a[31:2]));
  endfunction

  function automatic void model_wr(input int d, input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s);
    logic [31:0] w;
    if (a < MEM_BYTES) begin
      w = model_rd(d, a);
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = dat[8*i +: 8];
      mem_m[mkey(d, a)] = w;
    end
  endfunction

  // Monitor: pops expected responses on handshakes and checks valid/data stability
  bit          pr_stall [2];
  bit          pb_stall [2];
  logic [31:0] pr_data  [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        pr_stall[d] = 1'b0;
        pb_stall[d] = 1'b0;
      end else begin
        if (pr_stall[d]) begin
          check("rvalid_hold", 32'(rvalid[d]), 32'd1);
          check("rdata_hold", rdata[d], pr_data[d]);
        end
        if (pb_stall[d]) check("bvalid_hold", 32'(bvalid[d]), 32'd1);
        if (rvalid[d] && rready[d]) begin
          if (d == 0) begin
            check("r_outstanding0", 32'(rexp0.size() > 0), 32'd1);
            if (rexp0.size() > 0) check("rdata0", rdata[0], rexp0.pop_front());
          end else begin
            check("r_outstanding1", 32'(rexp1.size() > 0), 32'd1);
            if (rexp1.size() > 0) check("rdata1", rdata[1], rexp1.pop_front());
          end
        end
        if (bvalid[d] && bready[d]) begin
          check("b_outstanding", 32'(bexp[d] > 0), 32'd1);
          if (bexp[d] > 0) bexp[d]--;
        end
        pr_stall[d] = rvalid[d] && !rready[d];
        pr_data[d]  = rdata[d];
        pb_stall[d] = bvalid[d] && !bready[d];
      end
    end
  end

  // All tasks start and end just after a rising edge
  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly, output int lat);
    bit aw_done = 0, w_done = 0, b_done = 0;
    int cyc = 0, hs_cyc = 0, bv_cyc = -1, bwait = 0;
    bexp[d]++;
    while (!b_done && cyc < TMO) begin
      awvalid[d] = !aw_done && (cyc >= aw_dly);
      awaddr[d]  = a;
      wvalid[d]  = !w_done && (cyc >= w_dly);
      wdata[d]   = dat;
      wstrb[d]   = s;
      bready[d]  = (bwait >= b_dly);
      @(negedge clk);
      if (aw_done) check("awready_busy", 32'(awready[d]), 32'd0);
      if (w_done)  check("wready_busy", 32'(wready[d]), 32'd0);
      if (awvalid[d] && awready[d]) begin aw_done = 1; hs_cyc = cyc; end
      if (wvalid[d] && wready[d])   begin w_done = 1;  hs_cyc = cyc; end
      if (bvalid[d]) begin
        if (bv_cyc < 0) bv_cyc = cyc;
        if (bready[d]) b_done = 1; else bwait++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    awvalid[d] = 1'b0;
    wvalid[d]  = 1'b0;
    bready[d]  = 1'b0;
    check("write_done", 32'(b_done), 32'd1);
    lat = bv_cyc - hs_cyc;
    model_wr(d, a, dat, s);
  endtask

  task automatic do_read(input int d, input logic [31:0] a, input logic [31:0] exp,
                         input int ar_dly, input int r_dly, output int lat);
    bit ar_done = 0, r_done = 0;
    int cyc = 0, hs_cyc = 0, rv_cyc = -1, rwait = 0;
    if (d == 0) rexp0.push_back(exp); else rexp1.push_back(exp);
    while (!r_done && cyc < TMO) begin
      arvalid[d] = !ar_done && (cyc >= ar_dly);
      araddr[d]  = a;
      rready[d]  = (rwait >= r_dly);
      @(negedge clk);
      if (ar_done) check("arready_busy", 32'(arready[d]), 32'd0);
      if (arvalid[d] && arready[d]) begin ar_done = 1; hs_cyc = cyc; end
      if (rvalid[d]) begin
        if (rv_cyc < 0) rv_cyc = cyc;
        if (rready[d]) r_done = 1; else rwait++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    arvalid[d] = 1'b0;
    rready[d]  = 1'b0;
    check("read_done", 32'(r_done), 32'd1);
    lat = rv_cyc - hs_cyc;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, lat_r;
    logic [31:0] a, word;
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      awvalid[d] = 0; awaddr[d] = 0; wvalid[d] = 0; wdata[d] = 0; wstrb[d] = 0;
      bready[d] = 0; arvalid[d] = 0; araddr[d] = 0; rready[d] = 0; bexp[d] = 0;
    end
    for (int unsigned i = 0; i < MEM_WORDS; i++) begin
      u_dut0.memory[i] = init_word(0, i);
      u_dut1.memory[i] = init_word(1, i);
    end
    @(posedge clk); #1;
    do_reset();

    // Post-reset state
    @(negedge clk);
    check("rst_bvalid", 32'(bvalid[0]), 32'd0);
    check("rst_rvalid", 32'(rvalid[0]), 32'd0);
    check("rst_should_exit", 32'(sx[0]), 32'd0);
    check("rst_exit_code", 32'(ecode[0]), 32'd0);
    check("rst_awready", 32'(awready[0]), 32'd1);
    check("rst_wready", 32'(wready[0]), 32'd1);
    check("rst_arready", 32'(arready[0]), 32'd1);
    check("rst_bvalid1", 32'(bvalid[1]), 32'd0);
    check("rst_rvalid1", 32'(rvalid[1]), 32'd0);
    @(posedge clk); #1;

    // Basic write/read with latency
    do_write(0, 32'h100, 32'hA5A5A5A5, 4'hF, 0, 0, 0, lat);
    check("b_latency", 32'(lat), 32'd2);
    do_read(0, 32'h100, 32'hA5A5A5A5, 0, 0, lat);
    check("r_latency", 32'(lat), 32'd2);

    // Byte strobes; low address bits ignored
    do_write(0, 32'h200, 32'h11223344, 4'hF, 0, 0, 0, lat);
    do_write(0, 32'h200, 32'h0000BB00, 4'b0010, 0, 0, 0, lat);
    do_read(0, 32'h200, 32'h1122BB44, 0, 1, lat);
    do_write(0, 32'h203, 32'h77000000, 4'b1000, 0, 0, 0, lat);
    do_read(0, 32'h200, 32'h7722BB44, 2, 0, lat);

    // AW leads W, B back-pressured; then W leads AW
    do_write(0, 32'h204, 32'hDEADBEEF, 4'hF, 0, 3, 2, lat);
    check("b_latency_aw_first", 32'(lat), 32'd2);
    do_write(0, 32'h208, 32'hFEEDFACE, 4'hF, 2, 0, 1, lat);
    check("b_latency_w_first", 32'(lat), 32'd2);
    do_read(0, 32'h204, 32'hDEADBEEF, 0, 3, lat);
    do_read(0, 32'h208, 32'hFEEDFACE, 1, 0, lat);

    // Read load and write commit on the same edge: read sees old data
    fork
      do_write(0, 32'h100, 32'h5A5A0000, 4'hF, 0, 0, 0, lat);
      do_read(0, 32'h100, 32'hA5A5A5A5, 0, 0, lat_r);
    join
    do_read(0, 32'h100, 32'h5A5A0000, 0, 0, lat);

    // Last word in range, preloaded contents, word 0
    do_read(0, MEM_BYTES - 4, init_word(0, MEM_WORDS - 1), 0, 0, lat);
    do_write(0, MEM_BYTES - 4, 32'h0BADCAFE, 4'hF, 0, 0, 0, lat);
    do_read(0, MEM_BYTES - 4, 32'h0BADCAFE, 0, 0, lat);
    do_write(0, 32'h0, 32'h01020304, 4'hF, 0, 0, 0, lat);
    do_write(0, 32'h300, 32'hCAFEF00D, 4'hF, 0, 0, 0, lat);

    // Console write leaves exit state alone
    do_write(0, 32'h1000_0000, 32'h0000000A, 4'h1, 0, 0, 0, lat);
    check("console_no_exit", 32'(sx[0]), 32'd0);

    // Exit mailbox
    do_write(0, 32'h2000_0000, 32'h7, 4'hF, 0, 0, 0, lat);
    check("exit_flag", 32'(sx[0]), 32'd1);
    check("exit_code7", 32'(ecode[0]), 32'd7);
    do_read(0, 32'h0010_0000, 32'h0, 0, 0, lat);
    check("exit_after_badrd", 32'(sx[0]), 32'd1);
    check("exit_code_kept", 32'(ecode[0]), 32'd7);
    do_write(0, 32'h2000_0000, 32'h9, 4'hF, 0, 0, 0, lat);
    check("exit_code_first", 32'(ecode[0]), 32'd7);

    // Reset on the would-be commit edge discards the held write
    awvalid[0] = 1'b1; awaddr[0] = 32'h300;
    wvalid[0] = 1'b1; wdata[0] = 32'h12345678; wstrb[0] = 4'hF;
    @(negedge clk);
    check("mid_awready", 32'(awready[0]), 32'd1);
    check("mid_wready", 32'(wready[0]), 32'd1);
    @(posedge clk); #1;
    awvalid[0] = 1'b0; wvalid[0] = 1'b0; resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("mid_bvalid", 32'(bvalid[0]), 32'd0);
    check("mid_awready_idle", 32'(awready[0]), 32'd1);
    check("rst2_should_exit", 32'(sx[0]), 32'd0);
    check("rst2_exit_code", 32'(ecode[0]), 32'd0);
    @(posedge clk); #1;
    do_read(0, 32'h300, 32'hCAFEF00D, 0, 0, lat);
    do_read(0, 32'h100, 32'h5A5A0000, 0, 0, lat);

    // Unmapped write: ignored, exit with 0xFFFF, no aliasing onto word 0
    do_write(0, 32'h3000_0000, 32'h55, 4'hF, 0, 0, 0, lat);
    check("bad_wr_exit", 32'(sx[0]), 32'd1);
    check("bad_wr_code", 32'(ecode[0]), 32'h0000FFFF);
    do_read(0, 32'h0, 32'h01020304, 0, 0, lat);
    do_read(0, MEM_BYTES, 32'h0, 0, 0, lat);

    // Randomized traffic under pseudo-random stalls
    for (int n = 0; n < int'(N_RAND); n++) begin
      if ($urandom_range(0, 9) == 0) word = MEM_WORDS - 1 - $urandom_range(0, 3);
      else word = $urandom_range(0, 63);
      a = (word << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        do_write(1, a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), lat);
        check("rand_b_latency_min", 32'(lat >= 2), 32'd1);
      end else begin
        do_read(1, a, model_rd(1, a), $urandom_range(0, 3), $urandom_range(0, 3), lat);
        check("rand_r_latency_min", 32'(lat >= 2), 32'd1);
      end
    end
    check("rand_should_exit", 32'(sx[1]), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("rexp_drained", 32'(rexp0.size() + rexp1.size()), 32'd0);
    check("bexp_drained", 32'(bexp[0] + bexp[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
